clk_div_ctrl: RTL and testbench

Programmable clock-enable divider with a run/stop controller and a config handshake. Generates a divided square wave `div_out` and a one-cycle period `tick` from `clk`. Divide ratios change only at period boundaries, so `div_out` never shows a runt pulse. It sits beside the fixed-ratio dividers and feeds slow-domain enables to downstream blocks.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_ctrl_div_core.sv | 73 +++++++
 rtl/clk_div_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_div_pkg                                                |
// | Description : Shared types and constants for the programmable clock-     |
// |               enable divider (controller state encoding, minimum ratio). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package clk_div_pkg;

   // Controller states. SWITCH means a new ratio is parked in the pending
   // register, waiting for the current period to finish.
   typedef enum logic [1:0] {
      STOP   = 2'd0,
      RUN    = 2'd1,
      SWITCH = 2'd2
   } state_e;

   // Smallest ratio that still yields both a low and a high phase.
   localparam int unsigned MIN_DIV = 2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_core                                                   |
// | Description : Period counter with registered square-wave and tick        |
// |               outputs. Holds the ratio currently in effect.              |
// | Ports       : clk, rst      - clock, synchronous active-high reset       |
// |               run           - count while high; hold count 0 when low    |
// |               load/load_div - replace the ratio (only issued in STOP or  |
// |                               on the last count of a period)             |
// |               cur_div       - ratio in effect                            |
// |               at_end        - count is on the last step of the period    |
// |               div_out, tick - divided output, end-of-period pulse        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_div,
   output logic [CNT_W-1:0] cur_div,
   output logic             at_end,
   output logic             div_out,
   output logic             tick
);

   logic [CNT_W-1:0] count_q,   count_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic             div_out_q, div_out_d;
   logic             tick_q,    tick_d;

   assign at_end = (count_q == cur_div_q - CNT_W'(1));

   always_comb begin
      cur_div_d = load ? load_div : cur_div_q;

      // A load always lands on a period boundary, so the counter restarts.
      count_d = '0;
      if (run && !load && !at_end) begin
         count_d = count_q + CNT_W'(1);
      end

      // Compare against the ratio of the cycle being entered so a freshly
      // loaded ratio shapes its very first period.
      div_out_d = run && (count_d >= (cur_div_d >> 1));
      tick_d    = run && at_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         cur_div_q <= CNT_W'(DEFAULT_DIV);
         div_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         cur_div_q <= cur_div_d;
         div_out_q <= div_out_d;
         tick_q    <= tick_d;
      end
   end

   assign cur_div = cur_div_q;
   assign div_out = div_out_q;
   assign tick    = tick_q;

endmodule : div_core
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_div_ctrl                                               |
// | Description : Programmable clock-enable divider with run/stop control    |
// |               and a ratio handshake. Ratio changes only take effect at   |
// |               period boundaries so div_out never shows a runt pulse.     |
// | Ports       : clk, rst            - clock, sync active-high reset        |
// |               en                  - run request (level)                  |
// |               cfg_valid/cfg_div   - offered ratio                        |
// |               cfg_ready           - ratio can be accepted                |
// |               cfg_err             - one-cycle pulse on rejected ratio    |
// |               div_out, tick       - divided output, end-of-period pulse  |
// |               busy                - controller not stopped               |
// |               cur_div             - ratio in effect                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_out,
   output logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             cfg_err_q, cfg_err_d;

   logic             accept;
   logic             cfg_ok;
   logic             at_end;
   logic             load;
   logic [CNT_W-1:0] load_div;

   // Only a parked ratio blocks new offers.
   assign cfg_ready = (state_q != SWITCH);
   assign busy      = (state_q != STOP);
   assign accept    = cfg_valid && cfg_ready;
   assign cfg_ok    = (cfg_div >= CNT_W'(MIN_DIV));

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      load      = 1'b0;
      load_div  = cfg_div;
      cfg_err_d = accept && !cfg_ok;

      case (state_q)
         STOP: begin
            if (accept && cfg_ok) begin
               load = 1'b1;
            end
            if (en) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (accept && cfg_ok && !at_end) begin
               state_d   = SWITCH;
               pending_d = cfg_div;
            end else if (at_end) begin
               // A ratio offered on the last count lands on the same edge
               // as the wrap, so no parking is needed.
               if (accept && cfg_ok) begin
                  load = 1'b1;
               end
               if (!en) begin
                  state_d = STOP;
               end
            end
         end

         SWITCH: begin
            if (at_end) begin
               load     = 1'b1;
               load_div = pending_q;
               state_d  = en ? RUN : STOP;
            end
         end

         default: begin
            state_d = STOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= STOP;
         pending_q <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   div_core #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div_core (
      .clk      (clk),
      .rst      (rst),
      .run      (busy),
      .load     (load),
      .load_div (load_div),
      .cur_div  (cur_div),
      .at_end   (at_end),
      .div_out  (div_out),
      .tick     (tick)
   );

endmodule : clk_div_ctrl
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_clk_div_ctrl                                            |
// | Description : Directed scoreboard bench for clk_div_ctrl. Stimulus      |
// |               queues expected output values tagged with the cycle they  |
// |               must appear in; a monitor checks them on the falling edge.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_clk_div_ctrl;

   localparam int S_DIV = 0;
   localparam int S_TICK = 1;
   localparam int S_BUSY = 2;
   localparam int S_CUR = 3;
   localparam int S_RDY = 4;
   localparam int S_ERR = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       div_out;
   logic       tick;
   logic       busy;
   logic [7:0] cur_div;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sbq[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   t;

   clk_div_ctrl #(
      .CNT_W       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .div_out   (div_out),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] actual(int s);
      case (s)
         S_DIV:   return {7'd0, div_out};
         S_TICK:  return {7'd0, tick};
         S_BUSY:  return {7'd0, busy};
         S_CUR:   return cur_div;
         S_RDY:   return {7'd0, cfg_ready};
         S_ERR:   return {7'd0, cfg_err};
         default: return 8'hxx;
      endcase
   endfunction

   // Monitor: every entry due this cycle is compared and retired.
   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc <= cyc) begin
            total++;
            if (sbq[i].cyc < cyc) begin
               bad++;
               $display("FAIL %s: stale entry for cycle %0d seen at %0d",
                        sbq[i].name, sbq[i].cyc, cyc);
            end else if (actual(sbq[i].sig) !== sbq[i].val) begin
               bad++;
               $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                        sbq[i].name, cyc, actual(sbq[i].sig), sbq[i].val);
            end
            sbq.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_at(int c, int s, int v, string name);
      exp_t e;
      e.cyc  = c;
      e.sig  = s;
      e.val  = v[7:0];
      e.name = name;
      sbq.push_back(e);
   endtask

   // Expected div_out / tick bit strings, one character per cycle.
   task automatic push_wave(int start, string d, string tk, string name);
      for (int i = 0; i < d.len(); i++) begin
         exp_at(start + i, S_DIV, (d[i] == "1") ? 1 : 0, {name, "_div"});
         exp_at(start + i, S_TICK, (tk[i] == "1") ? 1 : 0, {name, "_tick"});
      end
   endtask

   task automatic push_reset_vals(int c, string name);
      exp_at(c, S_DIV, 0, {name, "_div"});
      exp_at(c, S_TICK, 0, {name, "_tick"});
      exp_at(c, S_BUSY, 0, {name, "_busy"});
      exp_at(c, S_CUR, 4, {name, "_cur"});
      exp_at(c, S_RDY, 1, {name, "_rdy"});
      exp_at(c, S_ERR, 0, {name, "_err"});
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
      step(); step();

      // Reset, then run at the default ratio 4, then stop at count 1.
      t = cyc;
      push_reset_vals(t, "reset");
      rst = 1'b0; en = 1'b1;
      exp_at(t + 1, S_BUSY, 1, "run4_busy");
      push_wave(t + 1, "001100110", "000010001", "run4");
      repeat (10) step();
      en = 1'b0;
      push_wave(t + 11, "1100", "0010", "stop4");
      exp_at(t + 12, S_BUSY, 1, "stop4_busy_mid");
      exp_at(t + 13, S_BUSY, 0, "stop4_busy_end");
      exp_at(t + 14, S_BUSY, 0, "stop4_busy_hold");
      repeat (4) step();

      // Rejected ratios 1 and 0.
      t = cyc;
      cfg_valid = 1'b1; cfg_div = 8'd1;
      exp_at(t + 1, S_ERR, 1, "rej1_err");
      exp_at(t + 1, S_CUR, 4, "rej1_cur");
      exp_at(t + 1, S_RDY, 1, "rej1_rdy");
      exp_at(t + 2, S_ERR, 0, "rej1_err_clr");
      exp_at(t + 3, S_ERR, 1, "rej0_err");
      exp_at(t + 3, S_CUR, 4, "rej0_cur");
      exp_at(t + 4, S_ERR, 0, "rej0_err_clr");
      exp_at(t + 4, S_BUSY, 0, "rej_busy");
      step();
      cfg_valid = 1'b0;
      step();
      cfg_valid = 1'b1; cfg_div = 8'd0;
      step();
      cfg_valid = 1'b0;
      step();

      // Ratio 6 loaded in STOP, then run; then boundary accept of 4.
      t = cyc;
      cfg_valid = 1'b1; cfg_div = 8'd6;
      exp_at(t + 1, S_CUR, 6, "stop6_cur");
      exp_at(t + 1, S_BUSY, 0, "stop6_busy");
      push_wave(t + 2, "0001110", "0000001", "run6");
      exp_at(t + 8, S_CUR, 6, "run6_cur");
      step();
      cfg_valid = 1'b0; en = 1'b1;
      repeat (12) step();
      cfg_valid = 1'b1; cfg_div = 8'd4;
      exp_at(t + 14, S_CUR, 4, "bnd4_cur");
      exp_at(t + 14, S_RDY, 1, "bnd4_rdy");
      exp_at(t + 15, S_RDY, 1, "bnd4_rdy_next");
      exp_at(t + 15, S_BUSY, 1, "bnd4_busy");
      push_wave(t + 14, "00110", "10001", "bnd4");
      step();
      cfg_valid = 1'b0;
      repeat (5) step();

      // Mid-period switch 4 -> 3 at count 1.
      cfg_valid = 1'b1; cfg_div = 8'd3;
      exp_at(t + 20, S_RDY, 0, "sw3_rdy0");
      exp_at(t + 21, S_RDY, 0, "sw3_rdy1");
      exp_at(t + 21, S_CUR, 4, "sw3_cur_old");
      exp_at(t + 22, S_RDY, 1, "sw3_rdy_back");
      exp_at(t + 22, S_CUR, 3, "sw3_cur_new");
      push_wave(t + 20, "1101101", "0010010", "sw3");
      step();
      cfg_valid = 1'b0;
      repeat (8) step();

      // Park 7 in SWITCH, then reset; 7 must never be applied.
      t = cyc;
      cfg_valid = 1'b1; cfg_div = 8'd7;
      exp_at(t + 1, S_RDY, 0, "sw7_rdy");
      step();
      cfg_valid = 1'b0; rst = 1'b1;
      push_reset_vals(t + 2, "rst_sw");
      step();
      rst = 1'b0;
      exp_at(t + 3, S_BUSY, 1, "post_rst_busy");
      push_wave(t + 3, "00110", "00001", "post_rst");
      exp_at(t + 7, S_CUR, 4, "post_rst_cur");
      repeat (8) step();

      // Simultaneous en fall and boundary accept of 5.
      t = cyc;
      en = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd5;
      exp_at(t + 1, S_CUR, 5, "fall5_cur");
      exp_at(t + 1, S_BUSY, 0, "fall5_busy");
      exp_at(t + 1, S_RDY, 1, "fall5_rdy");
      push_wave(t + 1, "00", "10", "fall5");
      exp_at(t + 2, S_BUSY, 0, "fall5_busy_hold");
      exp_at(t + 2, S_CUR, 5, "fall5_cur_hold");
      step();
      cfg_valid = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
      while (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: never checked (due cycle %0d)", sbq[0].name, sbq[0].cyc);
         sbq.delete(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_clk_div_ctrl
`default_nettype wire
